cpu_machine_ctl: RTL and testbench

- Instruction-cycle controller; the consumer of the CPU clock generator's `fetch` strobe.
- Once started by `fetch`, it steps an 8-phase instruction cycle, S0..S7, and issues the datapath control strobes for the current opcode: PC, IR, ACC, memory read/write, data-bus drive and halt.
- Sits between the clock generator, the instruction register (opcode, zero flag) and the datapath.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_ctl_decode.sv | 65 ++++++
 rtl/cpu_machine_ctl.sv | 74 +++++++
 tb/tb_cpu_machine_ctl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the instruction-cycle controller: opcodes, one-hot states, strobe bit positions.
// No logic; pure declarations.
// No flow control.
package cpu_pkg;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam int ST_W = 10;

    localparam logic [ST_W-1:0] ST_IDLE   = 10'b00_0000_0001;
    localparam logic [ST_W-1:0] ST_S0     = 10'b00_0000_0010;
    localparam logic [ST_W-1:0] ST_S1     = 10'b00_0000_0100;
    localparam logic [ST_W-1:0] ST_S2     = 10'b00_0000_1000;
    localparam logic [ST_W-1:0] ST_S3     = 10'b00_0001_0000;
    localparam logic [ST_W-1:0] ST_S4     = 10'b00_0010_0000;
    localparam logic [ST_W-1:0] ST_S5     = 10'b00_0100_0000;
    localparam logic [ST_W-1:0] ST_S6     = 10'b00_1000_0000;
    localparam logic [ST_W-1:0] ST_S7     = 10'b01_0000_0000;
    localparam logic [ST_W-1:0] ST_HALTED = 10'b10_0000_0000;

    localparam int STB_W        = 8;
    localparam int STB_INC_PC   = 0;
    localparam int STB_LOAD_PC  = 1;
    localparam int STB_LOAD_IR  = 2;
    localparam int STB_LOAD_ACC = 3;
    localparam int STB_RD       = 4;
    localparam int STB_WR       = 5;
    localparam int STB_DATACTL  = 6;
    localparam int STB_HALT     = 7;

endpackage

// File: rtl/cpu_ctl_decode.sv
// Maps the state about to be entered, plus opcode/zero, to the datapath strobe bundle.
// Combinational, zero latency; the top registers the result.
// No flow control.
module cpu_ctl_decode
    import cpu_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  logic [ST_W-1:0]  next_state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic [STB_W-1:0] strobes
);

    logic op_hlt, op_skz, op_sto, op_jmp, op_alu;

    always_comb begin
        op_hlt = (opcode == OPC_W'(OP_HLT));
        op_skz = (opcode == OPC_W'(OP_SKZ));
        op_sto = (opcode == OPC_W'(OP_STO));
        op_jmp = (opcode == OPC_W'(OP_JMP));
        op_alu = (opcode == OPC_W'(OP_ADD))  || (opcode == OPC_W'(OP_ANDD)) ||
                 (opcode == OPC_W'(OP_XORR)) || (opcode == OPC_W'(OP_LDA));
    end

    always_comb begin
        strobes = '0;
        case (next_state)
            ST_S0, ST_S1: begin
                strobes[STB_LOAD_IR] = 1'b1;
                strobes[STB_RD]      = 1'b1;
                strobes[STB_INC_PC]  = 1'b1;
            end
            ST_S3: begin
                strobes[STB_INC_PC] = op_hlt;
                strobes[STB_HALT]   = op_hlt;
            end
            ST_S4: begin
                strobes[STB_RD]      = op_alu;
                strobes[STB_LOAD_PC] = op_jmp;
                strobes[STB_DATACTL] = op_sto;
            end
            ST_S5: begin
                strobes[STB_RD]       = op_alu;
                strobes[STB_LOAD_ACC] = op_alu;
                strobes[STB_INC_PC]   = (op_skz && zero) || op_jmp;
                strobes[STB_LOAD_PC]  = op_jmp;
                strobes[STB_DATACTL]  = op_sto;
                strobes[STB_WR]       = op_sto;
            end
            ST_S6: begin
                strobes[STB_RD]      = op_alu;
                strobes[STB_DATACTL] = op_sto;
            end
            ST_S7: begin
                strobes[STB_INC_PC] = op_skz && zero;
            end
            ST_HALTED: begin
                strobes[STB_HALT] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_machine_ctl.sv
// Instruction-cycle controller: steps S0..S7 after fetch and drives registered datapath strobes.
// Strobes for a state appear right after the edge that enters it (fetch at edge t -> S0 strobes after t).
// No backpressure; runs free once started, stops only in HALTED or on reset.
module cpu_machine_ctl
    import cpu_pkg::*;
#(
    parameter bit HALT_STICKY = 1'b1,
    parameter int OPC_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_ir,
    output logic             load_acc,
    output logic             rd,
    output logic             wr,
    output logic             datactl_ena,
    output logic             halt
);

    logic [ST_W-1:0]  state, next_state;
    logic [STB_W-1:0] stb, stb_nxt;

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:   next_state = fetch ? ST_S0 : ST_IDLE;
            ST_S0:     next_state = ST_S1;
            ST_S1:     next_state = ST_S2;
            ST_S2:     next_state = ST_S3;
            ST_S3:     next_state = (HALT_STICKY && (opcode == OPC_W'(OP_HLT))) ? ST_HALTED : ST_S4;
            ST_S4:     next_state = ST_S5;
            ST_S5:     next_state = ST_S6;
            ST_S6:     next_state = ST_S7;
            ST_S7:     next_state = ST_S0;
            ST_HALTED: next_state = ST_HALTED;
            default:   next_state = ST_IDLE;
        endcase
    end

    cpu_ctl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .next_state (next_state),
        .opcode     (opcode),
        .zero       (zero),
        .strobes    (stb_nxt)
    );

    // Strobes are decoded from the state being entered so they line up with it after the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            stb   <= '0;
        end else begin
            state <= next_state;
            stb   <= stb_nxt;
        end
    end

    assign inc_pc      = stb[STB_INC_PC];
    assign load_pc     = stb[STB_LOAD_PC];
    assign load_ir     = stb[STB_LOAD_IR];
    assign load_acc    = stb[STB_LOAD_ACC];
    assign rd          = stb[STB_RD];
    assign wr          = stb[STB_WR];
    assign datactl_ena = stb[STB_DATACTL];
    assign halt        = stb[STB_HALT];

endmodule

// File: tb/tb_cpu_machine_ctl.sv
// Directed bench for cpu_machine_ctl: vector table for the opcode cycles, hand sequences for halt and reset.
module tb_cpu_machine_ctl;

    // Output byte order: {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt}
    localparam logic [7:0] E_FT  = 8'hA8;
    localparam logic [7:0] E_NO  = 8'h00;
    localparam logic [7:0] E_RD  = 8'h08;
    localparam logic [7:0] E_ACC = 8'h18;
    localparam logic [7:0] E_DC  = 8'h02;
    localparam logic [7:0] E_WR  = 8'h06;
    localparam logic [7:0] E_INC = 8'h80;
    localparam logic [7:0] E_HLT = 8'h81;
    localparam logic [7:0] E_HO  = 8'h01;
    localparam logic [7:0] E_JP4 = 8'h40;
    localparam logic [7:0] E_JP5 = 8'hC0;

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, STO = 3'b110, LDA = 3'b101, JMP = 3'b111;

    typedef struct {
        logic       fetch;
        logic [2:0] opcode;
        logic       zero;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fetch = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic zero = 1'b0;

    logic s_inc, s_lpc, s_lir, s_lacc, s_rd, s_wr, s_dc, s_halt;
    logic n_inc, n_lpc, n_lir, n_lacc, n_rd, n_wr, n_dc, n_halt;
    logic [7:0] o_s, o_n;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cpu_machine_ctl #(.HALT_STICKY(1'b1), .OPC_W(3)) dut (
        .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
        .inc_pc(s_inc), .load_pc(s_lpc), .load_ir(s_lir), .load_acc(s_lacc),
        .rd(s_rd), .wr(s_wr), .datactl_ena(s_dc), .halt(s_halt)
    );

    cpu_machine_ctl #(.HALT_STICKY(1'b0), .OPC_W(3)) dut_ns (
        .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
        .inc_pc(n_inc), .load_pc(n_lpc), .load_ir(n_lir), .load_acc(n_lacc),
        .rd(n_rd), .wr(n_wr), .datactl_ena(n_dc), .halt(n_halt)
    );

    assign o_s = {s_inc, s_lpc, s_lir, s_lacc, s_rd, s_wr, s_dc, s_halt};
    assign o_n = {n_inc, n_lpc, n_lir, n_lacc, n_rd, n_wr, n_dc, n_halt};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic f, input logic [2:0] op, input logic z, input logic [7:0] e);
        vec_t v;
        v.fetch = f; v.opcode = op; v.zero = z; v.exp = e;
        vecs.push_back(v);
    endtask

    // e holds the S0..S7 expected bytes, S0 in the top byte.
    task automatic add_instr(input logic f, input logic [2:0] op, input logic z, input logic [63:0] e);
        for (int i = 0; i < 8; i++)
            addv((i == 0) ? f : 1'b0, op, z, e[63 - 8*i -: 8]);
    endtask

    initial begin
        addv(1'b0, LDA, 1'b0, E_NO);
        add_instr(1'b1, LDA, 1'b0, {E_FT, E_FT, E_NO, E_NO, E_RD, E_ACC, E_RD, E_NO});
        add_instr(1'b0, STO, 1'b0, {E_FT, E_FT, E_NO, E_NO, E_DC, E_WR, E_DC, E_NO});
        add_instr(1'b0, SKZ, 1'b1, {E_FT, E_FT, E_NO, E_NO, E_NO, E_INC, E_NO, E_INC});
        add_instr(1'b0, SKZ, 1'b0, {E_FT, E_FT, E_NO, E_NO, E_NO, E_NO, E_NO, E_NO});
        add_instr(1'b1, JMP, 1'b0, {E_FT, E_FT, E_NO, E_NO, E_JP4, E_JP5, E_NO, E_NO});

        step();
        chk("reset_state", o_s, E_NO);
        chk("reset_state_ns", o_n, E_NO);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            fetch = vecs[i].fetch;
            opcode = vecs[i].opcode;
            zero = vecs[i].zero;
            step();
            chk($sformatf("vec%0d", i), o_s, vecs[i].exp);
            chk($sformatf("vec%0d_ns", i), o_n, vecs[i].exp);
            chk($sformatf("vec%0d_inv", i), {s_rd & s_wr, s_wr & ~s_dc}, 8'h00);
        end
        fetch = 1'b0;

        // HLT: sticky parks in HALTED, non-sticky pulses halt once and carries on.
        reset = 1'b1;
        step();
        reset = 1'b0;
        opcode = HLT;
        fetch = 1'b1;
        step();
        chk("hlt_s0", o_s, E_FT);
        fetch = 1'b0;
        step();
        step();
        chk("hlt_s2", o_s, E_NO);
        step();
        chk("hlt_s3", o_s, E_HLT);
        chk("hlt_s3_ns", o_n, E_HLT);
        for (int k = 0; k < 20; k++) begin
            fetch = k[0];
            step();
            chk($sformatf("halted%0d", k), o_s, E_HO);
            if (k < 5)
                chk($sformatf("hlt_ns_after%0d", k), o_n, (k == 4) ? E_FT : E_NO);
        end
        fetch = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("halt_async_rst", o_s, E_NO);
        step();
        reset = 1'b0;
        step();
        chk("halt_rst_idle", o_s, E_NO);

        // JMP with reset landing between edges while in S4.
        opcode = JMP;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        repeat (4) step();
        chk("jmp_s4", o_s, E_JP4);
        #2;
        reset = 1'b1;
        #1;
        chk("jmp_async_rst", o_s, E_NO);
        chk("jmp_async_rst_ns", o_n, E_NO);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("jmp_idle%0d", k), o_s, E_NO);
        end
        fetch = 1'b1;
        step();
        chk("jmp_refetch", o_s, E_FT);
        fetch = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
